// File: rtl/chess_clock_pkg.sv
// Shared types and BCD MM:SS arithmetic for the two-player chess clock.
package chess_clock_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN_P1  = 3'd1,
    RUN_P2  = 3'd2,
    PAUSED  = 3'd3,
    FLAGGED = 3'd4
  } state_e;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
  } mmss_t;

  localparam int MAX_MM = 99;
  localparam int MAX_SS = 59;

  function automatic mmss_t mmss_from_bin(input logic [7:0] mm, input logic [7:0] ss);
    mmss_t r;
    logic [7:0] tmp;
    tmp = mm / 8'd10;
    r.min_tens = tmp[3:0];
    tmp = mm % 8'd10;
    r.min_ones = tmp[3:0];
    tmp = ss / 8'd10;
    r.sec_tens = tmp[3:0];
    tmp = ss % 8'd10;
    r.sec_ones = tmp[3:0];
    return r;
  endfunction

  // One-second decrement with borrow; 00:00 holds so the time never underflows.
  function automatic mmss_t mmss_dec(input mmss_t t);
    mmss_t r;
    r = t;
    if (t.sec_ones != 4'd0) begin
      r.sec_ones = t.sec_ones - 4'd1;
    end else if (t.sec_tens != 4'd0) begin
      r.sec_tens = t.sec_tens - 4'd1;
      r.sec_ones = 4'd9;
    end else if (t.min_ones != 4'd0) begin
      r.min_ones = t.min_ones - 4'd1;
      r.sec_tens = 4'd5;
      r.sec_ones = 4'd9;
    end else if (t.min_tens != 4'd0) begin
      r.min_tens = t.min_tens - 4'd1;
      r.min_ones = 4'd9;
      r.sec_tens = 4'd5;
      r.sec_ones = 4'd9;
    end else begin
      r = t;
    end
    return r;
  endfunction

  function automatic mmss_t mmss_add_sec(input mmss_t t, input logic [6:0] inc);
    logic [7:0] secs;
    logic [7:0] mins;
    secs = {4'd0, t.sec_tens} * 8'd10 + {4'd0, t.sec_ones} + {1'b0, inc};
    mins = {4'd0, t.min_tens} * 8'd10 + {4'd0, t.min_ones};
    if (secs > 8'(MAX_SS)) begin
      secs = secs - 8'd60;
      mins = mins + 8'd1;
    end else begin
      secs = secs;
    end
    if (mins > 8'(MAX_MM)) begin
      return mmss_from_bin(8'(MAX_MM), 8'(MAX_SS));
    end else begin
      return mmss_from_bin(mins, secs);
    end
  endfunction

endpackage

// File: rtl/bcd_mmss_counter.sv
// One player's remaining time: BCD countdown with borrow, saturating increment, zero detect.
module bcd_mmss_counter
  import chess_clock_pkg::*;
#(
  parameter int INC_SEC = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec,
  input  logic        add_inc,
  input  logic [15:0] load_val,
  output logic [15:0] mmss,
  output logic        zero
);

  mmss_t time_q;
  mmss_t time_d;
  mmss_t dec_s;

  // A same-cycle tick and hand-over apply the decrement before the increment.
  always_comb begin
    dec_s  = time_q;
    time_d = time_q;
    if (dec) begin
      dec_s = mmss_dec(time_q);
    end else begin
      dec_s = time_q;
    end
    if (add_inc) begin
      time_d = mmss_add_sec(dec_s, 7'(INC_SEC));
    end else begin
      time_d = dec_s;
    end
  end

  // Time register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_q <= mmss_t'(load_val);
    end else begin
      time_q <= time_d;
    end
  end

  assign mmss = time_q;
  assign zero = (time_q == mmss_t'(16'h0000));

endmodule

// File: rtl/chess_clock_timer.sv
// Chess clock core: turn FSM, one-second prescaler and two BCD time counters.
module chess_clock_timer
  import chess_clock_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int START_MIN = 5,
  parameter int INC_SEC   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p1_press,
  input  logic        p2_press,
  input  logic        pause,
  output logic [15:0] p1_digits,
  output logic [15:0] p2_digits,
  output logic [1:0]  active,
  output logic [1:0]  flag
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] CNT_MAX = PW'(CLK_HZ - 1);
  localparam logic [15:0] START_VAL = {4'(START_MIN / 10), 4'(START_MIN % 10), 8'h00};

  state_e        state_q;
  state_e        resume_q;
  logic [PW-1:0] cnt_q;
  logic [1:0]    active_q;
  logic [1:0]    flag_q;

  logic tick_s, timeout_s, handover_s, own_press_s;
  logic p1_only_s, p2_only_s, p1_last_s, p2_last_s;
  logic p1_zero_s, p2_zero_s;
  logic dec1_s, dec2_s, inc1_s, inc2_s;

  // Control strobes; pause takes priority over ticks and presses in the running states.
  always_comb begin
    p1_only_s   = p1_press & ~p2_press;
    p2_only_s   = p2_press & ~p1_press;
    p1_last_s   = (p1_digits == 16'h0001) | p1_zero_s;
    p2_last_s   = (p2_digits == 16'h0001) | p2_zero_s;
    tick_s      = 1'b0;
    own_press_s = 1'b0;
    timeout_s   = 1'b0;
    if (!pause && state_q == RUN_P1) begin
      tick_s      = (cnt_q == CNT_MAX);
      own_press_s = p1_only_s;
      timeout_s   = tick_s & p1_last_s;
    end else if (!pause && state_q == RUN_P2) begin
      tick_s      = (cnt_q == CNT_MAX);
      own_press_s = p2_only_s;
      timeout_s   = tick_s & p2_last_s;
    end else begin
      tick_s = 1'b0;
    end
    handover_s = own_press_s & ~timeout_s;
    dec1_s     = tick_s & (state_q == RUN_P1);
    dec2_s     = tick_s & (state_q == RUN_P2);
    inc1_s     = handover_s & (state_q == RUN_P1);
    inc2_s     = handover_s & (state_q == RUN_P2);
  end

  // Turn FSM with prescaler and registered active/flag outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      resume_q <= RUN_P1;
      cnt_q    <= '0;
      active_q <= 2'b00;
      flag_q   <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (!pause && p2_only_s) begin
            state_q  <= RUN_P1;
            active_q <= 2'b01;
            cnt_q    <= '0;
          end else if (!pause && p1_only_s) begin
            state_q  <= RUN_P2;
            active_q <= 2'b10;
            cnt_q    <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN_P1, RUN_P2: begin
          if (pause) begin
            resume_q <= state_q;
            state_q  <= PAUSED;
            active_q <= 2'b00;
          end else if (timeout_s) begin
            state_q  <= FLAGGED;
            active_q <= 2'b00;
            flag_q   <= flag_q | ((state_q == RUN_P1) ? 2'b01 : 2'b10);
          end else if (handover_s) begin
            state_q  <= (state_q == RUN_P1) ? RUN_P2 : RUN_P1;
            active_q <= (state_q == RUN_P1) ? 2'b10 : 2'b01;
            cnt_q    <= '0;
          end else begin
            cnt_q <= tick_s ? '0 : cnt_q + PW'(1);
          end
        end
        PAUSED: begin
          if (!pause) begin
            state_q  <= resume_q;
            active_q <= (resume_q == RUN_P1) ? 2'b01 : 2'b10;
          end else begin
            state_q <= PAUSED;
          end
        end
        FLAGGED: begin
          state_q  <= FLAGGED;
          active_q <= 2'b00;
        end
        default: begin
          state_q  <= IDLE;
          active_q <= 2'b00;
          cnt_q    <= '0;
        end
      endcase
    end
  end

  bcd_mmss_counter #(.INC_SEC(INC_SEC)) u_p1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .dec     (dec1_s),
    .add_inc (inc1_s),
    .load_val(START_VAL),
    .mmss    (p1_digits),
    .zero    (p1_zero_s)
  );

  bcd_mmss_counter #(.INC_SEC(INC_SEC)) u_p2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .dec     (dec2_s),
    .add_inc (inc2_s),
    .load_val(START_VAL),
    .mmss    (p2_digits),
    .zero    (p2_zero_s)
  );

  assign active = active_q;
  assign flag   = flag_q;

endmodule

// File: tb/tb_chess_clock_timer.sv
// Directed bench for chess_clock_timer with CLK_HZ=4, START_MIN=1, INC_SEC=2.
module tb_chess_clock_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p1_press = 1'b0;
  logic        p2_press = 1'b0;
  logic        pause = 1'b0;
  logic [15:0] p1_digits;
  logic [15:0] p2_digits;
  logic [1:0]  active;
  logic [1:0]  flag;

  int n_cmp = 0;
  int n_bad = 0;

  chess_clock_timer #(.CLK_HZ(4), .START_MIN(1), .INC_SEC(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .p1_press (p1_press),
    .p2_press (p2_press),
    .pause    (pause),
    .p1_digits(p1_digits),
    .p2_digits(p2_digits),
    .active   (active),
    .flag     (flag)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; p1_press = 1'b0; p2_press = 1'b0; pause = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Press is sampled on the next posedge; returns at the negedge after it.
  task automatic pulse(input logic a, input logic b);
    @(negedge clk);
    p1_press = a; p2_press = b;
    @(negedge clk);
    p1_press = 1'b0; p2_press = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (20) @(negedge clk);
    n_cmp++; if (p1_digits !== 16'h0100) begin n_bad++; $display("FAIL reset_p1 got %h exp 0100", p1_digits); end
    n_cmp++; if (p2_digits !== 16'h0100) begin n_bad++; $display("FAIL reset_p2 got %h exp 0100", p2_digits); end
    n_cmp++; if (active !== 2'b00) begin n_bad++; $display("FAIL reset_active got %b exp 00", active); end
    n_cmp++; if (flag !== 2'b00) begin n_bad++; $display("FAIL reset_flag got %b exp 00", flag); end
  endtask

  task automatic test_run_handover();
    do_reset();
    pulse(1'b0, 1'b1);
    repeat (8) @(negedge clk);
    n_cmp++; if (active !== 2'b01) begin n_bad++; $display("FAIL run_active got %b exp 01", active); end
    n_cmp++; if (p1_digits !== 16'h0058) begin n_bad++; $display("FAIL run_p1 got %h exp 0058", p1_digits); end
    n_cmp++; if (p2_digits !== 16'h0100) begin n_bad++; $display("FAIL run_p2 got %h exp 0100", p2_digits); end
    pulse(1'b1, 1'b0);
    n_cmp++; if (active !== 2'b10) begin n_bad++; $display("FAIL hand_active got %b exp 10", active); end
    n_cmp++; if (p1_digits !== 16'h0100) begin n_bad++; $display("FAIL hand_inc_p1 got %h exp 0100", p1_digits); end
    repeat (4) @(negedge clk);
    n_cmp++; if (p2_digits !== 16'h0059) begin n_bad++; $display("FAIL hand_p2_dec got %h exp 0059", p2_digits); end
    n_cmp++; if (p1_digits !== 16'h0100) begin n_bad++; $display("FAIL hand_p1_hold got %h exp 0100", p1_digits); end
  endtask

  task automatic test_tick_press();
    do_reset();
    pulse(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    pulse(1'b1, 1'b0);
    n_cmp++; if (p1_digits !== 16'h0101) begin n_bad++; $display("FAIL tickpress_p1 got %h exp 0101", p1_digits); end
    n_cmp++; if (active !== 2'b10) begin n_bad++; $display("FAIL tickpress_active got %b exp 10", active); end
  endtask

  task automatic test_timeout();
    do_reset();
    pulse(1'b0, 1'b1);
    repeat (239) @(negedge clk);
    n_cmp++; if (p1_digits !== 16'h0001) begin n_bad++; $display("FAIL pre_to_p1 got %h exp 0001", p1_digits); end
    n_cmp++; if (flag !== 2'b00) begin n_bad++; $display("FAIL pre_to_flag got %b exp 00", flag); end
    @(negedge clk);
    n_cmp++; if (flag !== 2'b01) begin n_bad++; $display("FAIL to_flag got %b exp 01", flag); end
    n_cmp++; if (p1_digits !== 16'h0000) begin n_bad++; $display("FAIL to_p1 got %h exp 0000", p1_digits); end
    n_cmp++; if (active !== 2'b00) begin n_bad++; $display("FAIL to_active got %b exp 00", active); end
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    pause = 1'b1;
    repeat (10) @(negedge clk);
    pause = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++; if (flag !== 2'b01) begin n_bad++; $display("FAIL flagged_flag got %b exp 01", flag); end
    n_cmp++; if (active !== 2'b00) begin n_bad++; $display("FAIL flagged_active got %b exp 00", active); end
    n_cmp++; if (p1_digits !== 16'h0000) begin n_bad++; $display("FAIL flagged_p1 got %h exp 0000", p1_digits); end
    n_cmp++; if (p2_digits !== 16'h0100) begin n_bad++; $display("FAIL flagged_p2 got %h exp 0100", p2_digits); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (p1_digits !== 16'h0100) begin n_bad++; $display("FAIL async_rst_p1 got %h exp 0100", p1_digits); end
    n_cmp++; if (flag !== 2'b00) begin n_bad++; $display("FAIL async_rst_flag got %b exp 00", flag); end
    rst_n = 1'b1;
  endtask

  task automatic test_pause();
    do_reset();
    pulse(1'b1, 1'b0);
    repeat (6) @(negedge clk);
    n_cmp++; if (p2_digits !== 16'h0059) begin n_bad++; $display("FAIL prepause_p2 got %h exp 0059", p2_digits); end
    pause = 1'b1;
    repeat (50) @(negedge clk);
    pulse(1'b0, 1'b1);
    repeat (48) @(negedge clk);
    n_cmp++; if (p2_digits !== 16'h0059) begin n_bad++; $display("FAIL pause_p2 got %h exp 0059", p2_digits); end
    n_cmp++; if (p1_digits !== 16'h0100) begin n_bad++; $display("FAIL pause_p1 got %h exp 0100", p1_digits); end
    pause = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (p2_digits !== 16'h0059) begin n_bad++; $display("FAIL resume_early got %h exp 0059", p2_digits); end
    n_cmp++; if (active !== 2'b10) begin n_bad++; $display("FAIL resume_active got %b exp 10", active); end
    @(negedge clk);
    n_cmp++; if (p2_digits !== 16'h0058) begin n_bad++; $display("FAIL resume_phase got %h exp 0058", p2_digits); end
  endtask

  task automatic test_both_press();
    do_reset();
    pulse(1'b1, 1'b1);
    n_cmp++; if (active !== 2'b00) begin n_bad++; $display("FAIL both_idle got %b exp 00", active); end
    pause = 1'b1;
    pulse(1'b0, 1'b1);
    n_cmp++; if (active !== 2'b00) begin n_bad++; $display("FAIL pause_idle got %b exp 00", active); end
    pause = 1'b0;
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b1);
    n_cmp++; if (active !== 2'b01) begin n_bad++; $display("FAIL both_run got %b exp 01", active); end
    n_cmp++; if (p1_digits !== 16'h0100) begin n_bad++; $display("FAIL both_run_p1 got %h exp 0100", p1_digits); end
    pulse(1'b0, 1'b1);
    n_cmp++; if (active !== 2'b01) begin n_bad++; $display("FAIL opp_press got %b exp 01", active); end
  endtask

  task automatic test_tick_press_timeout();
    do_reset();
    pulse(1'b0, 1'b1);
    repeat (238) @(negedge clk);
    pulse(1'b1, 1'b0);
    n_cmp++; if (flag !== 2'b01) begin n_bad++; $display("FAIL tpto_flag got %b exp 01", flag); end
    n_cmp++; if (active !== 2'b00) begin n_bad++; $display("FAIL tpto_active got %b exp 00", active); end
    n_cmp++; if (p1_digits !== 16'h0000) begin n_bad++; $display("FAIL tpto_p1 got %h exp 0000", p1_digits); end
    n_cmp++; if (p2_digits !== 16'h0100) begin n_bad++; $display("FAIL tpto_p2 got %h exp 0100", p2_digits); end
  endtask

  initial begin
    test_reset();
    test_run_handover();
    test_tick_press();
    test_timeout();
    test_pause();
    test_both_press();
    test_tick_press_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
